fdiv_seq: RTL and testbench

Iterative IEEE-754 single-precision divider, y = x1 / x2. It is the inverse-operation companion to the pipelined `fmul` in the FPU and shares its operand/result naming (x1, x2, y). It is a multi-cycle unit with a start/done handshake and a fixed latency. The mantissa quotient is produced one bit per cycle by restoring division.

---
 rtl/fdiv_seq_if.sv | 12 +
 rtl/fdiv_seq.sv | 142 ++++++++++++++
 tb/tb_fdiv_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fdiv_seq_if.sv
// Start/done handshake bundle for the iterative single-precision divider.
interface fdiv_seq_if;
    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        busy;
    logic        done;
    logic [31:0] y;

    modport master (output start, output x1, output x2, input busy, input done, input y);
    modport slave  (input start, input x1, input x2, output busy, output done, output y);
endinterface

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 single-precision divider (y = x1 / x2).
// Restoring division produces one quotient bit per cycle; the latency is fixed at 27 cycles.
module fdiv_seq (
    input  logic      clk,
    input  logic      rst,
    fdiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

    state_t      state, state_nxt;
    logic        load, iter, finish;
    logic [4:0]  count;
    logic [25:0] r;
    logic [23:0] d;
    logic [25:0] q;
    logic [25:0] diff;
    logic        ge;
    logic        sign;
    logic [7:0]  e1, e2;
    logic        x1_nan, x1_inf, x1_zero;
    logic        x2_nan, x2_inf, x2_zero;
    logic signed [9:0] exp_raw;
    logic [31:0] result;
    logic        done_q;
    logic [31:0] y_q;

    // Normalize the quotient, round to nearest-even, and apply range limits.
    function automatic logic [31:0] round_pack(input logic [25:0] qv, input logic rem_nz,
                                               input logic signed [9:0] e_in, input logic s);
        logic [22:0]       frac;
        logic              guard, sticky, inc;
        logic signed [9:0] e;
        logic [23:0]       sum;
        if (qv[25]) begin
            frac   = qv[24:2];
            guard  = qv[1];
            sticky = qv[0] | rem_nz;
            e      = e_in;
        end else begin
            frac   = qv[23:1];
            guard  = qv[0];
            sticky = rem_nz;
            e      = e_in - 10'sd1;
        end
        inc = guard & (sticky | frac[0]);
        sum = {1'b0, frac} + {23'd0, inc};
        if (sum[23]) begin
            frac = 23'd0;
            e    = e + 10'sd1;
        end else begin
            frac = sum[22:0];
        end
        if (e >= 10'sd255)
            round_pack = {s, 8'hff, 23'd0};
        else if (e <= 10'sd0)
            round_pack = {s, 31'd0};
        else
            round_pack = {s, e[7:0], frac};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        iter      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                iter = 1'b1;
                if (count == 5'd25) state_nxt = ROUND;
            end
            ROUND: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 5'd0;
            done_q <= 1'b0;
            y_q    <= 32'd0;
        end else begin
            done_q <= finish;
            if (load)        count <= 5'd0;
            else if (iter)   count <= count + 5'd1;
            if (finish)      y_q   <= result;
        end
    end

    assign diff = r - {2'b00, d};
    assign ge   = (r >= {2'b00, d});

    // Operand capture on the accepting edge, then one restoring step per DIV cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            sign    <= bus.x1[31] ^ bus.x2[31];
            e1      <= bus.x1[30:23];
            e2      <= bus.x2[30:23];
            x1_nan  <= (bus.x1[30:23] == 8'hff) && (bus.x1[22:0] != 23'd0);
            x1_inf  <= (bus.x1[30:23] == 8'hff) && (bus.x1[22:0] == 23'd0);
            x1_zero <= (bus.x1[30:23] == 8'h00);
            x2_nan  <= (bus.x2[30:23] == 8'hff) && (bus.x2[22:0] != 23'd0);
            x2_inf  <= (bus.x2[30:23] == 8'hff) && (bus.x2[22:0] == 23'd0);
            x2_zero <= (bus.x2[30:23] == 8'h00);
            r       <= {3'b001, bus.x1[22:0]};
            d       <= {1'b1, bus.x2[22:0]};
            q       <= 26'd0;
        end else if (iter) begin
            q <= {q[24:0], ge};
            r <= ge ? {diff[24:0], 1'b0} : {r[24:0], 1'b0};
        end
    end

    assign exp_raw = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;

    always_comb begin
        result = round_pack(q, (r != 26'd0), exp_raw, sign);
        if (x1_nan || x2_nan || (x1_zero && x2_zero) || (x1_inf && x2_inf))
            result = 32'h7fc00000;
        else if (x1_inf || x2_zero)
            result = {sign, 8'hff, 23'd0};
        else if (x1_zero || x2_inf)
            result = {sign, 31'd0};
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.y    = y_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed-vector bench for fdiv_seq: table of operands with hand-computed quotients plus handshake/reset sequences.
module tb_fdiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fdiv_seq_if bus();

    fdiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Issues one division and waits (bounded) for done; returns on the done cycle, #1 after the edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int poke,
                           output logic [31:0] res, output int lat, output logic busy_ok);
        bus.x1    = a;
        bus.x2    = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x1    = 32'hdeadbeef;
        bus.x2    = 32'h12345678;
        lat       = -1;
        busy_ok   = bus.busy;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke) begin
                bus.start = 1'b1;
                bus.x1    = 32'h3f800000;
                bus.x2    = 32'h40400000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        res       = bus.y;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        logic        saw_done;

        vecs[0]  = '{32'h41100000, 32'h40400000, 32'h40400000};
        vecs[1]  = '{32'h3f800000, 32'h40400000, 32'h3eaaaaab};
        vecs[2]  = '{32'h40c8f5c3, 32'h40000000, 32'h4048f5c3};
        vecs[3]  = '{32'h437f0000, 32'hc37f0000, 32'hbf800000};
        vecs[4]  = '{32'h3f800000, 32'h00000000, 32'h7f800000};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7fc00000};
        vecs[6]  = '{32'h80000000, 32'h40000000, 32'h80000000};
        vecs[7]  = '{32'h7fc00000, 32'h3f800000, 32'h7fc00000};
        vecs[8]  = '{32'h7f000000, 32'h3e800000, 32'h7f800000};
        vecs[9]  = '{32'h00800000, 32'h40000000, 32'h00000000};
        vecs[10] = '{32'h7f800000, 32'h7f800000, 32'h7fc00000};
        vecs[11] = '{32'hbf800000, 32'h7f800000, 32'h80000000};
        vecs[12] = '{32'h7f800000, 32'hbf800000, 32'hff800000};

        bus.start = 1'b0;
        bus.x1    = 32'd0;
        bus.x2    = 32'd0;

        #12;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_y", bus.y, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].a, vecs[i].b, 0, res, lat, busy_ok);
            check($sformatf("vec%0d_y", i), res, vecs[i].expv);
            check($sformatf("vec%0d_latency", i), lat, 27);
            check($sformatf("vec%0d_busy_during", i), {31'd0, busy_ok}, 32'd1);
            check($sformatf("vec%0d_busy_at_done", i), {31'd0, bus.busy}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
            check($sformatf("vec%0d_y_hold", i), bus.y, vecs[i].expv);
        end

        // Start re-asserted mid-division with 1/3 must be ignored.
        run_div(32'h41100000, 32'h40400000, 10, res, lat, busy_ok);
        check("ignored_start_y", res, 32'h40400000);
        check("ignored_start_latency", lat, 27);

        // Start held in the done cycle is accepted immediately.
        run_div(32'h3f800000, 32'h40400000, 0, res, lat, busy_ok);
        check("b2b_first_y", res, 32'h3eaaaaab);
        run_div(32'h40c8f5c3, 32'h40000000, 0, res, lat, busy_ok);
        check("b2b_second_y", res, 32'h4048f5c3);
        check("b2b_second_latency", lat, 27);

        // Asynchronous abort mid-division.
        @(posedge clk);
        #1;
        bus.x1    = 32'h41100000;
        bus.x2    = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_y", bus.y, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        check("abort_y_after", bus.y, 32'd0);

        run_div(32'h437f0000, 32'hc37f0000, 0, res, lat, busy_ok);
        check("post_reset_y", res, 32'hbf800000);
        check("post_reset_latency", lat, 27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
